// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the fetch unit and the LSU.
// Ports: clk/rst_n; fetch req/addr/kill/ack/rdata; lsu req/we/addr/wdata/sel/ack/rdata; mem port.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_kill_i,
   output logic        if_ack_o,
   output logic [31:0] if_rdata_o,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic [3:0]  lsu_sel_i,
   output logic        lsu_ack_o,
   output logic [31:0] lsu_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_sel_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_LSU,
      DRAIN_IF
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  starve_q;
   logic [3:0]  starve_d;
   logic [31:0] addr_q;
   logic [31:0] addr_d;
   logic [31:0] wdata_q;
   logic [31:0] wdata_d;
   logic [3:0]  sel_q;
   logic [3:0]  sel_d;
   logic        we_q;
   logic        we_d;

   logic        arb_en;
   logic        if_cand;
   logic        lsu_cand;
   logic        if_win;
   logic        lsu_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      sel_d       = sel_q;
      we_d        = we_q;
      arb_en      = 1'b0;
      if_cand     = 1'b0;
      lsu_cand    = 1'b0;
      if_win      = 1'b0;
      lsu_win     = 1'b0;
      if_ack_o    = 1'b0;
      if_rdata_o  = '0;
      lsu_ack_o   = 1'b0;
      lsu_rdata_o = '0;

      // The completing requester is left out of the ack-cycle
      // arbitration: its request line is still high but stale.
      unique case (state_q)
         IDLE: begin
            arb_en   = 1'b1;
            if_cand  = if_req_i && !if_kill_i;
            lsu_cand = lsu_req_i;
         end
         BUSY_IF: begin
            if (mem_ack_i) begin
               arb_en     = 1'b1;
               lsu_cand   = lsu_req_i;
               if_ack_o   = !if_kill_i;
               if_rdata_o = if_kill_i ? 32'h0 : mem_rdata_i;
            end else if (if_kill_i) begin
               state_d = DRAIN_IF;
            end
         end
         BUSY_LSU: begin
            if (mem_ack_i) begin
               arb_en      = 1'b1;
               if_cand     = if_req_i && !if_kill_i;
               lsu_ack_o   = 1'b1;
               lsu_rdata_o = mem_rdata_i;
            end
         end
         DRAIN_IF: begin
            if (mem_ack_i) begin
               arb_en   = 1'b1;
               lsu_cand = lsu_req_i;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (arb_en) begin
         if_win  = if_cand && (!lsu_cand || starve_q == LIMIT);
         lsu_win = lsu_cand && !if_win;
         unique case (1'b1)
            if_win: begin
               state_d = BUSY_IF;
               addr_d  = if_addr_i;
               wdata_d = '0;
               sel_d   = 4'hF;
               we_d    = 1'b0;
            end
            lsu_win: begin
               state_d = BUSY_LSU;
               addr_d  = lsu_addr_i;
               wdata_d = lsu_wdata_i;
               sel_d   = lsu_sel_i;
               we_d    = lsu_we_i;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (!if_req_i || if_win) begin
         starve_d = '0;
      end else if (lsu_win && starve_q != LIMIT) begin
         starve_d = starve_q + 4'd1;
      end
   end

   assign mem_req_o   = (state_q != IDLE);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_sel_o   = sel_q;
   assign mem_we_o    = we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed vector table, hand corner sequences, then random vs a reference model.
module tb_mem_port_arbiter;

   localparam int LIM = 4;
   localparam logic [31:0] IFA = 32'h0000_0100;
   localparam logic [31:0] LA  = 32'h0000_2000;
   localparam logic [31:0] LD  = 32'hDEAD_BEEF;
   localparam logic [3:0]  LS  = 4'h3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_kill_i;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic [3:0]  lsu_sel_i;
   logic        lsu_ack_o;
   logic [31:0] lsu_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_sel_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_kill_i(if_kill_i), .if_ack_o(if_ack_o),
      .if_rdata_o(if_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_sel_i(lsu_sel_i), .lsu_ack_o(lsu_ack_o),
      .lsu_rdata_o(lsu_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i)
   );

   typedef struct {
      string       nm;
      logic        ifr;
      logic        kill;
      logic        lr;
      logic        mack;
      logic [31:0] rd;
      int          kind;
      logic        eifa;
      logic        ela;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string nm, logic ifr, logic kill,
                               logic lr, logic mack, logic [31:0] rd,
                               int kind, logic eifa, logic ela);
      vec_t v;
      v.nm = nm; v.ifr = ifr; v.kill = kill; v.lr = lr;
      v.mack = mack; v.rd = rd; v.kind = kind;
      v.eifa = eifa; v.ela = ela;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(logic ifr, logic kill, logic lr,
                        logic mack, logic [31:0] rd);
      @(negedge clk);
      if_req_i = ifr; if_kill_i = kill; lsu_req_i = lr;
      mem_ack_i = mack; mem_rdata_i = rd;
      #1;
   endtask

   // kind: 0 = no transaction, 1 = fetch, 2 = LSU store
   task automatic chk_port(string nm, int kind);
      chk({nm, ".mreq"}, 32'(mem_req_o), 32'(kind != 0));
      if (kind == 1) begin
         chk({nm, ".addr"}, mem_addr_o, IFA);
         chk({nm, ".we"}, 32'(mem_we_o), 32'd0);
         chk({nm, ".sel"}, 32'(mem_sel_o), 32'hF);
         chk({nm, ".wdata"}, mem_wdata_o, 32'd0);
      end else if (kind == 2) begin
         chk({nm, ".addr"}, mem_addr_o, LA);
         chk({nm, ".we"}, 32'(mem_we_o), 32'd1);
         chk({nm, ".sel"}, 32'(mem_sel_o), 32'(LS));
         chk({nm, ".wdata"}, mem_wdata_o, LD);
      end
   endtask

   task automatic lsu_blocked_txn(string nm);
      drive(1, 1, 1, 0, 0);
      chk_port({nm, ".arb"}, 0);
      drive(1, 1, 1, 1, 32'h1234);
      chk_port({nm, ".busy"}, 2);
      chk({nm, ".lack"}, 32'(lsu_ack_o), 32'd1);
   endtask

   // Reference model state
   logic        m_busy;
   logic        m_own_if;
   logic        m_killed;
   int          m_cnt;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_sel;
   logic        m_we;

   initial begin
      logic e_ifa;
      logic e_la;
      logic ic;
      logic lc;
      logic fw;
      logic lw;
      logic prev_ifa;
      logic prev_la;
      logic prev_kill;

      rst_n = 1'b0;
      if_req_i = 0; if_addr_i = IFA; if_kill_i = 0;
      lsu_req_i = 0; lsu_we_i = 1; lsu_addr_i = LA;
      lsu_wdata_i = LD; lsu_sel_i = LS;
      mem_ack_i = 0; mem_rdata_i = 0;
      #1;
      chk("rst.mreq", 32'(mem_req_o), 0);
      chk("rst.addr", mem_addr_o, 0);
      chk("rst.sel", 32'(mem_sel_o), 0);
      chk("rst.wdata", mem_wdata_o, 0);
      chk("rst.we", 32'(mem_we_o), 0);
      chk("rst.ifack", 32'(if_ack_o), 0);
      chk("rst.lack", 32'(lsu_ack_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      tbl.push_back(mk("idle0",    0,0,0,0,0,           0,0,0));
      tbl.push_back(mk("if_arb",   1,0,0,0,0,           0,0,0));
      tbl.push_back(mk("if_busy0", 1,0,0,0,0,           1,0,0));
      tbl.push_back(mk("if_busy1", 1,0,0,0,0,           1,0,0));
      tbl.push_back(mk("if_ack",   1,0,0,1,32'hCAFE0001,1,1,0));
      tbl.push_back(mk("if_done",  0,0,0,0,0,           0,0,0));
      tbl.push_back(mk("both_arb", 1,0,1,0,0,           0,0,0));
      tbl.push_back(mk("lsu_busy", 1,0,1,0,0,           2,0,0));
      tbl.push_back(mk("lsu_ack",  1,0,1,1,32'h11112222,2,0,1));
      tbl.push_back(mk("if_next",  1,0,0,0,0,           1,0,0));
      tbl.push_back(mk("if_ack2",  1,0,0,1,32'h33334444,1,1,0));
      tbl.push_back(mk("idle2",    0,0,0,0,0,           0,0,0));
      tbl.push_back(mk("k_arb",    1,0,0,0,0,           0,0,0));
      tbl.push_back(mk("k_busy",   1,0,0,0,0,           1,0,0));
      tbl.push_back(mk("k_ack",    1,1,0,1,32'h55556666,1,0,0));
      tbl.push_back(mk("k_idle",   0,0,0,0,0,           0,0,0));
      tbl.push_back(mk("d_arb",    1,0,0,0,0,           0,0,0));
      tbl.push_back(mk("d_kill",   1,1,1,0,0,           1,0,0));
      tbl.push_back(mk("d_drain",  0,0,1,0,0,           1,0,0));
      tbl.push_back(mk("d_ack",    0,0,1,1,32'h77778888,1,0,0));
      tbl.push_back(mk("d_lsu",    0,0,1,0,0,           2,0,0));
      tbl.push_back(mk("d_lack",   0,0,1,1,32'h00000009,2,0,1));
      tbl.push_back(mk("d_idle",   0,0,0,0,0,           0,0,0));
      tbl.push_back(mk("ki_arb",   1,1,0,0,0,           0,0,0));
      tbl.push_back(mk("ki_arb2",  1,0,0,0,0,           0,0,0));
      tbl.push_back(mk("ki_ack",   1,0,0,1,32'h0000000A,1,1,0));
      tbl.push_back(mk("ki_idle",  0,0,0,0,0,           0,0,0));

      foreach (tbl[i]) begin
         drive(tbl[i].ifr, tbl[i].kill, tbl[i].lr,
               tbl[i].mack, tbl[i].rd);
         chk_port(tbl[i].nm, tbl[i].kind);
         chk({tbl[i].nm, ".ifack"}, 32'(if_ack_o), 32'(tbl[i].eifa));
         chk({tbl[i].nm, ".lack"}, 32'(lsu_ack_o), 32'(tbl[i].ela));
         chk({tbl[i].nm, ".ifrd"}, if_rdata_o,
             tbl[i].eifa ? tbl[i].rd : 32'h0);
         chk({tbl[i].nm, ".lrd"}, lsu_rdata_o,
             tbl[i].ela ? tbl[i].rd : 32'h0);
      end

      // Starvation: four LSU grants with fetch waiting, then fetch wins.
      for (int n = 0; n < LIM; n++) lsu_blocked_txn("st_a");
      drive(1, 0, 1, 0, 0);
      chk_port("st_a.arb", 0);
      drive(1, 0, 1, 0, 0);
      chk_port("st_a.fetch_wins", 1);
      drive(1, 0, 0, 1, 32'hABCD0000);
      chk("st_a.ifack", 32'(if_ack_o), 1);
      drive(0, 0, 0, 0, 0);
      chk_port("st_a.idle", 0);
      // Counter restarted: one grant short of the limit, LSU still wins.
      for (int n = 0; n < LIM - 1; n++) lsu_blocked_txn("st_b");
      drive(1, 0, 1, 0, 0);
      chk_port("st_b.arb", 0);
      drive(1, 0, 1, 0, 0);
      chk_port("st_b.lsu_wins", 2);
      drive(1, 0, 1, 1, 32'h1);
      chk("st_b.lack", 32'(lsu_ack_o), 1);
      drive(1, 0, 0, 0, 0);
      chk_port("st_b.fetch_next", 1);
      drive(1, 0, 0, 1, 32'h2);
      chk("st_b.ifack", 32'(if_ack_o), 1);
      drive(0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of an LSU transaction.
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 32'h5);
      chk("ar.busy", 32'(mem_req_o), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar.mreq_async", 32'(mem_req_o), 0);
      chk("ar.lack_async", 32'(lsu_ack_o), 0);
      chk("ar.addr_async", mem_addr_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      lsu_req_i = 0;
      for (int n = 0; n < 3; n++) begin
         drive(0, 0, 0, 1, 32'h6);
         chk("ar.no_lack", 32'(lsu_ack_o), 0);
         chk("ar.no_mreq", 32'(mem_req_o), 0);
      end
      drive(0, 0, 1, 0, 0);
      chk_port("ar.rearb", 0);
      drive(0, 0, 1, 0, 0);
      chk_port("ar.regrant", 2);
      drive(0, 0, 1, 1, 32'h7);
      chk("ar.lack", 32'(lsu_ack_o), 1);

      // Random traffic against the reference model.
      @(negedge clk);
      rst_n = 1'b0;
      if_req_i = 0; if_kill_i = 0; lsu_req_i = 0; mem_ack_i = 0;
      @(negedge clk);
      rst_n = 1'b1;
      m_busy = 0; m_own_if = 0; m_killed = 0; m_cnt = 0;
      m_addr = 0; m_wdata = 0; m_sel = 0; m_we = 0;
      prev_ifa = 0; prev_la = 0; prev_kill = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!if_req_i || prev_ifa || prev_kill) begin
            if_req_i  = ($urandom % 3) == 0;
            if_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!lsu_req_i || prev_la) begin
            lsu_req_i   = ($urandom % 3) == 0;
            lsu_we_i    = $urandom % 2;
            lsu_addr_i  = $urandom;
            lsu_wdata_i = $urandom;
            lsu_sel_i   = 4'($urandom);
         end
         if_kill_i   = ($urandom % 8) == 0;
         mem_ack_i   = m_busy && (($urandom % 3) == 0);
         mem_rdata_i = $urandom;
         #1;

         e_ifa = m_busy && m_own_if && !m_killed &&
                 mem_ack_i && !if_kill_i;
         e_la  = m_busy && !m_own_if && mem_ack_i;
         chk("rnd.mreq", 32'(mem_req_o), 32'(m_busy));
         chk("rnd.ifack", 32'(if_ack_o), 32'(e_ifa));
         chk("rnd.lack", 32'(lsu_ack_o), 32'(e_la));
         chk("rnd.ifrd", if_rdata_o, e_ifa ? mem_rdata_i : 32'h0);
         chk("rnd.lrd", lsu_rdata_o, e_la ? mem_rdata_i : 32'h0);
         if (m_busy) begin
            chk("rnd.addr", mem_addr_o, m_addr);
            chk("rnd.wdata", mem_wdata_o, m_wdata);
            chk("rnd.sel", 32'(mem_sel_o), 32'(m_sel));
            chk("rnd.we", 32'(mem_we_o), 32'(m_we));
         end

         fw = 0;
         lw = 0;
         if (!m_busy || mem_ack_i) begin
            ic = if_req_i && !if_kill_i && !(m_busy && m_own_if);
            lc = lsu_req_i && !(m_busy && !m_own_if);
            fw = ic && (!lc || m_cnt == LIM);
            lw = lc && !fw;
            m_killed = 0;
            if (fw) begin
               m_busy = 1; m_own_if = 1;
               m_addr = if_addr_i; m_wdata = 0;
               m_sel = 4'hF; m_we = 0;
            end else if (lw) begin
               m_busy = 1; m_own_if = 0;
               m_addr = lsu_addr_i; m_wdata = lsu_wdata_i;
               m_sel = lsu_sel_i; m_we = lsu_we_i;
            end else begin
               m_busy = 0;
            end
         end else if (m_own_if && if_kill_i) begin
            m_killed = 1;
         end
         if (!if_req_i || fw) m_cnt = 0;
         else if (lw && m_cnt < LIM) m_cnt = m_cnt + 1;

         prev_ifa  = e_ifa;
         prev_la   = e_la;
         prev_kill = if_kill_i;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
